bp_fe_bht_update_sched: RTL and testbench

//  Buffers BHT counter-update requests from branch resolution and schedules them onto the BHT write port.

---
 rtl/bp_fe_bht_update_sched_if.sv | 38 +++
 rtl/bp_fe_bht_update_sched.sv | 119 +++++++++++
 tb/tb_bp_fe_bht_update_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bp_fe_bht_update_sched_if.sv
// Handshake bundle between the branch-resolution update path, the update scheduler and the BHT write port.
// The master modport is the environment view; the slave modport is the scheduler view.
interface bp_fe_bht_update_sched_if #(
    parameter int idx_w   = 6,
    parameter int off_w   = 1,
    parameter int ghist_w = 2,
    parameter int row_w   = 4
);
    logic               upd_v;
    logic               upd_ready_and;
    logic [idx_w-1:0]   upd_idx;
    logic [off_w-1:0]   upd_offset;
    logic [ghist_w-1:0] upd_ghist;
    logic [row_w-1:0]   upd_val;
    logic               upd_correct;

    logic               bht_w_v;
    logic [idx_w-1:0]   bht_w_idx;
    logic [off_w-1:0]   bht_w_offset;
    logic [ghist_w-1:0] bht_w_ghist;
    logic [row_w-1:0]   bht_w_val;
    logic               bht_w_correct;
    logic               bht_w_yumi;

    modport master (
        output upd_v, upd_idx, upd_offset, upd_ghist, upd_val, upd_correct,
        input  upd_ready_and,
        input  bht_w_v, bht_w_idx, bht_w_offset, bht_w_ghist, bht_w_val, bht_w_correct,
        output bht_w_yumi
    );

    modport slave (
        input  upd_v, upd_idx, upd_offset, upd_ghist, upd_val, upd_correct,
        output upd_ready_and,
        output bht_w_v, bht_w_idx, bht_w_offset, bht_w_ghist, bht_w_val, bht_w_correct,
        input  bht_w_yumi
    );
endinterface

// File: rtl/bp_fe_bht_update_sched.sv
// Queues BHT counter updates and schedules them onto the BHT write port, holding them until
// BHT init completes and blocking one FE read once writes have been refused for too long.
module bp_fe_bht_update_sched #(
    parameter int bht_idx_width_p    = 6,
    parameter int bht_offset_width_p = 1,
    parameter int ghist_width_p      = 2,
    parameter int bht_row_width_p    = 4,
    parameter int fifo_els_p         = 4,
    parameter int starve_limit_p     = 8,
    localparam int count_width_lp    = $clog2(fifo_els_p + 1),
    localparam int ptr_width_lp      = $clog2(fifo_els_p),
    localparam int starve_width_lp   = $clog2(starve_limit_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      flush_i,
    input  logic                      bht_init_done_i,
    bp_fe_bht_update_sched_if.slave   upd_if,
    output logic                      rd_block_o,
    output logic [count_width_lp-1:0] count_o
);

    typedef struct packed {
        logic [bht_idx_width_p-1:0]    idx;
        logic [bht_offset_width_p-1:0] offset;
        logic [ghist_width_p-1:0]      ghist;
        logic [bht_row_width_p-1:0]    val;
        logic                          correct;
    } entry_t;

    localparam logic [count_width_lp-1:0]  full_cnt_lp  = count_width_lp'(fifo_els_p);
    localparam logic [ptr_width_lp-1:0]    last_ptr_lp  = ptr_width_lp'(fifo_els_p - 1);
    localparam logic [starve_width_lp-1:0] starve_max_lp = starve_width_lp'(starve_limit_p);

    entry_t                       mem_q [fifo_els_p];
    entry_t                       mem_d [fifo_els_p];
    logic [ptr_width_lp-1:0]      head_q, head_d, tail_q, tail_d;
    logic [count_width_lp-1:0]    count_q, count_d;
    logic [starve_width_lp-1:0]   starve_q, starve_d;
    logic                         enq, deq, w_v;
    entry_t                       head_ent;

    assign w_v      = bht_init_done_i & (count_q != '0);
    assign head_ent = mem_q[head_q];

    assign upd_if.upd_ready_and = (count_q != full_cnt_lp) & ~flush_i;
    assign upd_if.bht_w_v       = w_v;
    assign upd_if.bht_w_idx     = head_ent.idx;
    assign upd_if.bht_w_offset  = head_ent.offset;
    assign upd_if.bht_w_ghist   = head_ent.ghist;
    assign upd_if.bht_w_val     = head_ent.val;
    assign upd_if.bht_w_correct = head_ent.correct;
    assign rd_block_o           = (starve_q == starve_max_lp);
    assign count_o              = count_q;

    always_comb begin
        enq     = upd_if.upd_v & upd_if.upd_ready_and;
        deq     = upd_if.bht_w_yumi;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (enq) begin
            mem_d[tail_q] = '{idx: upd_if.upd_idx, offset: upd_if.upd_offset,
                              ghist: upd_if.upd_ghist, val: upd_if.upd_val,
                              correct: upd_if.upd_correct};
            tail_d = (tail_q == last_ptr_lp) ? '0 : tail_q + 1'b1;
        end
        if (deq) begin
            head_d = (head_q == last_ptr_lp) ? '0 : head_q + 1'b1;
        end
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (deq && !enq) begin
            count_d = count_q - 1'b1;
        end

        // Flush wins over everything; a same-cycle yumi has already reached the BHT.
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (flush_i || deq || (count_q == '0)) begin
            starve_d = '0;
        end else if (w_v && (starve_q != starve_max_lp)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            for (int i = 0; i < fifo_els_p; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            mem_q    <= mem_d;
        end
    end

`ifndef SYNTHESIS
    yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (!reset_i)
        upd_if.bht_w_yumi |-> w_v);
`endif

endmodule

// File: tb/tb_bp_fe_bht_update_sched.sv
// Directed scenarios plus random traffic on the BHT update scheduler, checked against a queue-based model.
module tb_bp_fe_bht_update_sched;
    localparam int IW = 6, OW = 1, GW = 2, RW = 4, DEPTH = 4, LIM = 8;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [OW-1:0] off;
        logic [GW-1:0] gh;
        logic [RW-1:0] val;
        logic          c;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       init = 1'b0;
    logic       rd_block;
    logic [2:0] count;

    bp_fe_bht_update_sched_if #(.idx_w(IW), .off_w(OW), .ghist_w(GW), .row_w(RW)) u_if ();

    bp_fe_bht_update_sched #(
        .bht_idx_width_p(IW), .bht_offset_width_p(OW), .ghist_width_p(GW),
        .bht_row_width_p(RW), .fifo_els_p(DEPTH), .starve_limit_p(LIM)
    ) u_dut (
        .clk_i           (clk),
        .reset_i         (rst_n),
        .flush_i         (flush),
        .bht_init_done_i (init),
        .upd_if          (u_if.slave),
        .rd_block_o      (rd_block),
        .count_o         (count)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    int   starve = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t rnd_ent();
        logic [31:0] r;
        r = $urandom;
        return r[$bits(ent_t)-1:0];
    endfunction

    // One clock: drive inputs just after posedge, check mid-cycle, then advance the model.
    task automatic step(input logic fl, input logic v, input ent_t e, input logic ini, input logic y);
        logic ev, er, yy;
        ent_t h;
        ev = ini && (mq.size() != 0);
        er = (mq.size() != DEPTH) && !fl;
        yy = y && ev;
        flush = fl;
        init = ini;
        u_if.upd_v       = v;
        u_if.upd_idx     = e.idx;
        u_if.upd_offset  = e.off;
        u_if.upd_ghist   = e.gh;
        u_if.upd_val     = e.val;
        u_if.upd_correct = e.c;
        u_if.bht_w_yumi  = yy;
        #3;
        chk("ready", 32'(u_if.upd_ready_and), 32'(er));
        chk("w_v", 32'(u_if.bht_w_v), 32'(ev));
        chk("count", 32'(count), 32'(mq.size()));
        chk("rd_block", 32'(rd_block), 32'(starve == LIM));
        if (ev) begin
            h = mq[0];
            chk("w_fields", {u_if.bht_w_idx, u_if.bht_w_offset, u_if.bht_w_ghist,
                             u_if.bht_w_val, u_if.bht_w_correct}, 32'(h));
        end
        @(posedge clk);
        #1;
        if (fl || yy || mq.size() == 0) starve = 0;
        else if (ev) starve = (starve + 1 > LIM) ? LIM : starve + 1;
        if (fl) begin
            mq.delete();
        end else begin
            if (yy) void'(mq.pop_front());
            if (v && er) mq.push_back(e);
        end
    endtask

    initial begin
        ent_t e, z;
        z = '0;
        u_if.upd_v = 1'b0; u_if.upd_idx = '0; u_if.upd_offset = '0; u_if.upd_ghist = '0;
        u_if.upd_val = '0; u_if.upd_correct = 1'b0; u_if.bht_w_yumi = 1'b0;
        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_w_v", 32'(u_if.bht_w_v), 0);
        chk("rst_rd_block", 32'(rd_block), 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // single update, then write accepted
        e = '{idx: 6'd5, off: 1'b1, gh: 2'd2, val: 4'ha, c: 1'b0};
        step(0, 1, e, 1, 0);
        step(0, 0, z, 1, 1);
        step(0, 0, z, 1, 0);

        // queue fills before init, then drains in order
        for (int i = 0; i < 5; i++) step(0, 1, rnd_ent(), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, z, 1, 1);
        step(0, 0, z, 1, 0);

        // starvation: refused writes until rd_block, then accept
        step(0, 1, rnd_ent(), 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, z, 1, 0);
        step(0, 0, z, 1, 1);
        step(0, 0, z, 1, 0);

        // flush with a full queue, same-cycle update and yumi
        for (int i = 0; i < 4; i++) step(0, 1, rnd_ent(), 0, 0);
        step(1, 1, rnd_ent(), 1, 1);
        step(0, 0, z, 1, 0);

        // async reset mid-stream
        for (int i = 0; i < 3; i++) step(0, 1, rnd_ent(), 0, 0);
        init = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_w_v", 32'(u_if.bht_w_v), 0);
        chk("arst_rd_block", 32'(rd_block), 0);
        mq.delete();
        starve = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 1, rnd_ent(), 1, 0);
        step(0, 0, z, 1, 1);

        // steady enqueue+dequeue across pointer wrap
        step(0, 1, rnd_ent(), 1, 0);
        for (int i = 0; i < 20; i++) step(0, 1, rnd_ent(), 1, 1);
        step(0, 0, z, 1, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 60), rnd_ent(),
                 ($urandom_range(0, 99) < 90), ($urandom_range(0, 99) < 45));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
